iterative_alu: RTL and testbench

Execution stage directly downstream of the dual-read register file: consumes the two operand read ports (`read_data_1`, `read_data_2`) plus the shared 16-bit opcode. It produces the 16-bit result that the control unit routes back to the register file `write_data` port. Single-cycle ops (add/sub/logic/shift/compare) complete in one cycle. Multiply and divide/modulo run iteratively over 16 cycles behind a start/busy/done handshake, so the sequencer holds the ALU opcode until `done`.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_muldiv_core.sv | 86 ++++++++
 rtl/iterative_alu.sv | 185 ++++++++++++++++++
 tb/tb_iterative_alu.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the iterative ALU and its multiply/divide core.
package alu_pkg;

  localparam int DATA_WIDTH = 16;

  localparam logic [3:0] ALU_OP = 4'b0001;

  typedef enum logic [3:0] {
    SUBOP_ADD = 4'h0,
    SUBOP_SUB = 4'h1,
    SUBOP_AND = 4'h2,
    SUBOP_OR  = 4'h3,
    SUBOP_XOR = 4'h4,
    SUBOP_SHL = 4'h5,
    SUBOP_SHR = 4'h6,
    SUBOP_LT  = 4'h7,
    SUBOP_MUL = 4'h8,
    SUBOP_DIV = 4'h9,
    SUBOP_MOD = 4'hA
  } alu_subop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative shift-add multiplier and restoring divider, one bit per cycle.
// done/result are combinational on the final iteration so the owner can register them.
module alu_muldiv_core
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  alu_subop_e            subop,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DATA_WIDTH - 1);

  logic                  active_r;
  logic                  is_mul_r;
  logic                  is_mod_r;
  logic [CNT_W-1:0]      count_r;
  logic [DATA_WIDTH:0]   acc_r;     // product (low bits) or partial remainder
  logic [DATA_WIDTH-1:0] addend_r;  // multiplicand or divisor
  logic [DATA_WIDTH-1:0] shift_r;   // multiplier or dividend/quotient

  logic [DATA_WIDTH-1:0] mul_acc_s;
  logic [DATA_WIDTH:0]   rem_shift_s;
  logic [DATA_WIDTH+1:0] rem_diff_s;
  logic                  q_bit_s;
  logic [DATA_WIDTH:0]   rem_next_s;
  logic [DATA_WIDTH:0]   acc_next_s;
  logic [DATA_WIDTH-1:0] addend_next_s;
  logic [DATA_WIDTH-1:0] shift_next_s;

  // One iteration step for both the multiply and the restoring divide.
  always_comb begin
    mul_acc_s   = shift_r[0] ? (acc_r[DATA_WIDTH-1:0] + addend_r) : acc_r[DATA_WIDTH-1:0];
    rem_shift_s = {acc_r[DATA_WIDTH-1:0], shift_r[DATA_WIDTH-1]};
    rem_diff_s  = {1'b0, rem_shift_s} - {2'b00, addend_r};
    q_bit_s     = ~rem_diff_s[DATA_WIDTH+1];
    rem_next_s  = q_bit_s ? rem_diff_s[DATA_WIDTH:0] : rem_shift_s;
    if (is_mul_r) begin
      acc_next_s    = {1'b0, mul_acc_s};
      addend_next_s = {addend_r[DATA_WIDTH-2:0], 1'b0};
      shift_next_s  = {1'b0, shift_r[DATA_WIDTH-1:1]};
      result        = mul_acc_s;
    end else begin
      acc_next_s    = rem_next_s;
      addend_next_s = addend_r;
      shift_next_s  = {shift_r[DATA_WIDTH-2:0], q_bit_s};
      result        = is_mod_r ? rem_next_s[DATA_WIDTH-1:0] : shift_next_s;
    end
    done = active_r && (count_r == LAST_COUNT);
  end

  // Operand load on start, then one iteration per clock until the last count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_r <= 1'b0;
      is_mul_r <= 1'b0;
      is_mod_r <= 1'b0;
      count_r  <= {CNT_W{1'b0}};
      acc_r    <= {(DATA_WIDTH+1){1'b0}};
      addend_r <= {DATA_WIDTH{1'b0}};
      shift_r  <= {DATA_WIDTH{1'b0}};
    end else if (start) begin
      active_r <= 1'b1;
      is_mul_r <= (subop == SUBOP_MUL);
      is_mod_r <= (subop == SUBOP_MOD);
      count_r  <= {CNT_W{1'b0}};
      acc_r    <= {(DATA_WIDTH+1){1'b0}};
      addend_r <= operand_b;
      shift_r  <= operand_a;
    end else if (active_r) begin
      active_r <= ~done;
      count_r  <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      acc_r    <= acc_next_s;
      addend_r <= addend_next_s;
      shift_r  <= shift_next_s;
    end
  end

endmodule

// File: rtl/iterative_alu.sv
// ALU execution stage: single-cycle ops plus optional iterative MUL/DIV/MOD.
// Optional multiply/divide datapath enabled by defining ITERATIVE_ALU_MULDIV_EN.
module iterative_alu
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           opcode,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  zero,
  output logic                  div_zero
);

  state_e                state_r;
  logic                  done_r;
  logic [DATA_WIDTH-1:0] result_r;
  logic                  carry_r;
  logic                  zero_r;
  logic                  div_zero_r;

  alu_subop_e            subop_s;
  logic                  accept_s;
  logic [DATA_WIDTH:0]   sum_s;
  logic [DATA_WIDTH:0]   diff_s;
  logic [DATA_WIDTH-1:0] imm_result_s;
  logic                  imm_carry_s;
  logic                  imm_div_zero_s;
  logic                  imm_flagged_s;
  logic                  imm_zero_s;
  logic                  go_exec_s;
  logic                  core_done_s;
  logic [DATA_WIDTH-1:0] core_result_s;
  logic                  unused_opcode_s;

  assign unused_opcode_s = ^opcode[7:0];

  // Accept decode and single-cycle result; reserved sub-ops report no flags at all.
  always_comb begin
    subop_s        = alu_subop_e'(opcode[11:8]);
    accept_s       = start && (opcode[15:12] == ALU_OP) && (state_r != ST_EXEC);
    sum_s          = {1'b0, operand_a} + {1'b0, operand_b};
    diff_s         = {1'b0, operand_a} - {1'b0, operand_b};
    imm_result_s   = {DATA_WIDTH{1'b0}};
    imm_carry_s    = 1'b0;
    imm_div_zero_s = 1'b0;
    imm_flagged_s  = 1'b1;
    go_exec_s      = 1'b0;
    case (subop_s)
      SUBOP_ADD: begin
        imm_result_s = sum_s[DATA_WIDTH-1:0];
        imm_carry_s  = sum_s[DATA_WIDTH];
      end
      SUBOP_SUB: begin
        imm_result_s = diff_s[DATA_WIDTH-1:0];
        imm_carry_s  = diff_s[DATA_WIDTH];
      end
      SUBOP_AND: imm_result_s = operand_a & operand_b;
      SUBOP_OR:  imm_result_s = operand_a | operand_b;
      SUBOP_XOR: imm_result_s = operand_a ^ operand_b;
      SUBOP_SHL: imm_result_s = operand_a << operand_b[3:0];
      SUBOP_SHR: imm_result_s = operand_a >> operand_b[3:0];
      SUBOP_LT:  imm_result_s = {{(DATA_WIDTH-1){1'b0}}, diff_s[DATA_WIDTH]};
`ifdef ITERATIVE_ALU_MULDIV_EN
      SUBOP_MUL: go_exec_s = 1'b1;
      SUBOP_DIV: begin
        if (operand_b == {DATA_WIDTH{1'b0}}) begin
          imm_result_s   = {DATA_WIDTH{1'b1}};
          imm_div_zero_s = 1'b1;
        end else begin
          go_exec_s = 1'b1;
        end
      end
      SUBOP_MOD: begin
        if (operand_b == {DATA_WIDTH{1'b0}}) begin
          imm_result_s   = operand_a;
          imm_div_zero_s = 1'b1;
        end else begin
          go_exec_s = 1'b1;
        end
      end
`endif
      default: imm_flagged_s = 1'b0;
    endcase
    imm_zero_s = imm_flagged_s && (imm_result_s == {DATA_WIDTH{1'b0}});
  end

`ifdef ITERATIVE_ALU_MULDIV_EN
  logic core_start_s;
  logic busy_r;

  assign core_start_s = accept_s && go_exec_s;

  alu_muldiv_core #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_muldiv (
    .clk       (clk),
    .reset     (reset),
    .start     (core_start_s),
    .subop     (subop_s),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .done      (core_done_s),
    .result    (core_result_s)
  );

  // busy tracks residency in EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r <= 1'b0;
    end else if (core_start_s) begin
      busy_r <= 1'b1;
    end else if (core_done_s) begin
      busy_r <= 1'b0;
    end
  end

  assign busy = busy_r;
`else
  assign core_done_s   = 1'b0;
  assign core_result_s = {DATA_WIDTH{1'b0}};
  assign busy          = 1'b0;
`endif

  // Sequencing FSM with registered result and flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      done_r     <= 1'b0;
      result_r   <= {DATA_WIDTH{1'b0}};
      carry_r    <= 1'b0;
      zero_r     <= 1'b0;
      div_zero_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s && go_exec_s) begin
            state_r <= ST_EXEC;
            done_r  <= 1'b0;
          end else if (accept_s) begin
            state_r    <= ST_DONE;
            done_r     <= 1'b1;
            result_r   <= imm_result_s;
            carry_r    <= imm_carry_s;
            zero_r     <= imm_zero_s;
            div_zero_r <= imm_div_zero_s;
          end else begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
          end
        end
        ST_EXEC: begin
          if (core_done_s) begin
            state_r    <= ST_DONE;
            done_r     <= 1'b1;
            result_r   <= core_result_s;
            carry_r    <= 1'b0;
            zero_r     <= (core_result_s == {DATA_WIDTH{1'b0}});
            div_zero_r <= 1'b0;
          end else begin
            done_r <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign done     = done_r;
  assign result   = result_r;
  assign carry    = carry_r;
  assign zero     = zero_r;
  assign div_zero = div_zero_r;

endmodule

// File: tb/tb_iterative_alu.sv
// Directed table-driven bench for iterative_alu; expectations follow ITERATIVE_ALU_MULDIV_EN.
module tb_iterative_alu;

`ifdef ITERATIVE_ALU_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int ML = MD_EN ? 17 : 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] opcode;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        zero;
  logic        div_zero;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  iterative_alu dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .opcode    (opcode),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry     (carry),
    .zero      (zero),
    .div_zero  (div_zero)
  );

  typedef struct {
    logic [3:0]  sub;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] sub, input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] res, input logic c, input logic z, input logic dz,
                              input int lat);
    vec_t v;
    v.sub = sub; v.a = a; v.b = b; v.res = res; v.c = c; v.z = z; v.dz = dz; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " busy"}, busy, 0);
    chk({name, " done"}, done, 0);
    chk({name, " result"}, result, 0);
    chk({name, " carry"}, carry, 0);
    chk({name, " zero"}, zero, 0);
    chk({name, " div_zero"}, div_zero, 0);
  endtask

  // Called at the first negedge after the accepting edge (latency count 'first').
  task automatic wait_done(input string name, input int exp_lat, input int first);
    int lat;
    lat = first;
    while (done !== 1'b1 && lat < 40) begin
      chk({name, " busy"}, busy, exp_lat > 1);
      @(negedge clk);
      lat++;
    end
    chk({name, " latency"}, lat, exp_lat);
  endtask

  task automatic launch(input logic [3:0] sub, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1; opcode = {4'h1, sub, 8'h5A}; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0; opcode = 16'hFFFF; operand_a = ~a; operand_b = 16'h0000;
  endtask

  task automatic apply(input vec_t v, input string name);
    vectors++;
    launch(v.sub, v.a, v.b);
    wait_done(name, v.lat, 1);
    chk({name, " result"}, result, v.res);
    chk({name, " carry"}, carry, v.c);
    chk({name, " zero"}, zero, v.z);
    chk({name, " div_zero"}, div_zero, v.dz);
    chk({name, " busy_at_done"}, busy, 0);
    @(negedge clk);
    chk({name, " done_pulse"}, done, 0);
    chk({name, " result_held"}, result, v.res);
  endtask

  initial begin
    vec_t last;
    reset = 1'b1; start = 1'b0; opcode = 16'h0000; operand_a = 16'h0000; operand_b = 16'h0000;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset = 1'b0;

    vecs.push_back(mk(4'h0, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'h0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'h1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 1));
    vecs.push_back(mk(4'h1, 16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'h2, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'h3, 16'hF0F0, 16'h0F01, 16'hFFF1, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'h4, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'h4, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1));
    vecs.push_back(mk(4'h5, 16'h0001, 16'h0013, 16'h0008, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'h6, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'h6, 16'h8000, 16'h0010, 16'h8000, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'h7, 16'h0001, 16'h0002, 16'h0001, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'h7, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0, 1));
    vecs.push_back(mk(4'hB, 16'h1234, 16'h5678, 16'h0000, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1));
    vecs.push_back(mk(4'h8, 16'h0123, 16'h0010, MD_EN ? 16'h1230 : 16'h0000, 1'b0, 1'b0, 1'b0, ML));
    vecs.push_back(mk(4'h8, 16'hFFFF, 16'hFFFF, MD_EN ? 16'h0001 : 16'h0000, 1'b0, 1'b0, 1'b0, ML));
    vecs.push_back(mk(4'h8, 16'h0000, 16'h1234, 16'h0000, 1'b0, MD_EN, 1'b0, ML));
    vecs.push_back(mk(4'h9, 16'h0064, 16'h0007, MD_EN ? 16'h000E : 16'h0000, 1'b0, 1'b0, 1'b0, ML));
    vecs.push_back(mk(4'hA, 16'h0064, 16'h0007, MD_EN ? 16'h0002 : 16'h0000, 1'b0, 1'b0, 1'b0, ML));
    vecs.push_back(mk(4'h9, 16'h1234, 16'h0000, MD_EN ? 16'hFFFF : 16'h0000, 1'b0, 1'b0, MD_EN, 1));
    vecs.push_back(mk(4'hA, 16'h1234, 16'h0000, MD_EN ? 16'h1234 : 16'h0000, 1'b0, 1'b0, MD_EN, 1));
    vecs.push_back(mk(4'h9, 16'hFFFF, 16'h0001, MD_EN ? 16'hFFFF : 16'h0000, 1'b0, 1'b0, 1'b0, ML));
    vecs.push_back(mk(4'hA, 16'h0005, 16'h0009, MD_EN ? 16'h0005 : 16'h0000, 1'b0, 1'b0, 1'b0, ML));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d_op%0h", i, vecs[i].sub));
    end
    last = vecs[vecs.size() - 1];

    // Non-ALU major opcode: start must be ignored, previous result held.
    vectors++;
    @(negedge clk);
    start = 1'b1; opcode = 16'h2000; operand_a = 16'h0001; operand_b = 16'h0001;
    repeat (3) begin
      @(negedge clk);
      chk("non_alu done", done, 0);
      chk("non_alu result", result, last.res);
    end
    start = 1'b0;

    // Back-to-back: ADD launched in the DONE cycle of a MUL.
    vectors++;
    launch(4'h8, 16'h0123, 16'h0010);
    wait_done("b2b first", ML, 1);
    chk("b2b first result", result, MD_EN ? 16'h1230 : 16'h0000);
    start = 1'b1; opcode = 16'h1000; operand_a = 16'h0011; operand_b = 16'h0022;
    @(negedge clk);
    start = 1'b0; opcode = 16'hFFFF;
    chk("b2b second done", done, 1);
    chk("b2b second result", result, 16'h0033);
    @(negedge clk);
    chk("b2b second pulse", done, 0);

`ifdef ITERATIVE_ALU_MULDIV_EN
    // Start pulsed mid-EXEC is ignored; MUL still completes at its own latency.
    vectors++;
    launch(4'h8, 16'h0123, 16'h0010);
    repeat (4) @(negedge clk);
    start = 1'b1; opcode = 16'h1000; operand_a = 16'hFFFF; operand_b = 16'h0002;
    @(negedge clk);
    start = 1'b0; opcode = 16'hFFFF;
    wait_done("busy_start", 17, 6);
    chk("busy_start result", result, 16'h1230);
    chk("busy_start carry", carry, 0);

    // Reset in the 8th cycle of a MUL clears everything and suppresses done.
    vectors++;
    launch(4'h8, 16'h0123, 16'h0010);
    repeat (7) @(negedge clk);
    chk("mid_mul busy", busy, 1);
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_mul reset");
    reset = 1'b0;
    repeat (20) begin
      @(negedge clk);
      chk("mid_mul no done", done, 0);
    end
    apply(mk(4'h0, 16'h0F00, 16'h00F0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1), "after_reset_add");
`endif

    // Reset after a completed op clears the held result and flags.
    apply(mk(4'h0, 16'hFFFF, 16'h0002, 16'h0001, 1'b1, 1'b0, 1'b0, 1), "pre_reset_add");
    reset = 1'b1;
    @(negedge clk);
    chk_all_zero("post_op reset");
    reset = 1'b0;
    apply(mk(4'h1, 16'h0010, 16'h0001, 16'h000F, 1'b0, 1'b0, 1'b0, 1), "post_reset_sub");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
